cnn_frame_feeder: RTL
=====================

// Module: cnn_frame_feeder
// PURPOSE
//  Upstream stage of CNN_TOP. Accepts an 8-bit pixel stream from the sensor/DMA side over a valid/ready handshake.
//  Buffers one complete IMG_WIDTH x IMG_HEIGHT frame, then drives CNN_TOP's input protocol:
//  a 1-cycle start pulse, then the frame as an unbroken raster stream.
//  Holds off the next frame until CNN_TOP returns final_result_valid, or until a timeout expires.
// PARAMETERS
//  IMG_WIDTH      32       pixels per row
//  IMG_HEIGHT     32       rows per frame; TOTAL = IMG_WIDTH*IMG_HEIGHT, AW = $clog2(TOTAL)
//  TIMEOUT_CYCLES 100000   max cycles in WAIT_RES before abandoning the frame (>=1)
// PORTS
//  clk           in   1   clock; all logic on rising edge
//  rst           in   1   reset, synchronous, active-low
//  s_valid       in   1   upstream pixel valid
//  s_ready       out  1   feeder can accept a pixel this cycle
//  s_data        in   8   upstream pixel, raster order
//  s_last        in   1   marks last pixel of upstream frame
//  start_signal  out  1   to CNN_TOP: 1-cycle frame-start pulse
//  pixel_valid   out  1   to CNN_TOP: pixel_in valid
//  pixel_in      out  8   to CNN_TOP: pixel data
//  result_valid  in   1   from CNN_TOP final_result_valid
//  busy          out  1   1 in any state except FILL
//  frame_done    out  1   1-cycle pulse: result received for current frame
//  frame_err     out  1   1-cycle pulse: upstream frame length error
//  timeout       out  1   1-cycle pulse: WAIT_RES expired
//  frames_done   out  16  count of frame_done pulses; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst==0 at posedge), all outputs registered:
//   - state=FILL, wr_cnt=0, rd_cnt=0, tmo_cnt=0, frames_done=0.
//   - start_signal, pixel_valid, busy, frame_done, frame_err, timeout = 0; pixel_in = 0.
//   - s_ready = 0 during reset, 1 on the first cycle after release.
//   - Reset mid-operation aborts the frame: no further pixels, no frame_done.
//  FSM: FILL -> START -> STREAM -> WAIT_RES -> FILL; DROP on length error.
//   FILL: s_ready=1. Each beat (s_valid&s_ready) writes s_data to ram[wr_cnt], then wr_cnt++.
//    - Beat with wr_cnt==TOTAL-1 and s_last=1: frame complete -> START.
//    - Beat with s_last=1 and wr_cnt<TOTAL-1: frame_err pulse, wr_cnt=0, stay FILL (frame discarded).
//    - Beat with wr_cnt==TOTAL-1 and s_last=0: frame_err pulse -> DROP.
//   DROP: s_ready=1, beats discarded. Beat with s_last=1 -> FILL with wr_cnt=0.
//   START (1 cycle): s_ready=0, start_signal=1, RAM read of addr 0 issued, rd_cnt=1 -> STREAM.
//   STREAM: s_ready=0.
//    - pixel_valid=1 on the cycle after start_signal, for exactly TOTAL consecutive cycles.
//    - pixel_in = ram[k] on the k-th pixel_valid cycle (1-cycle sync RAM read, prefetched).
//    - After the cycle carrying ram[TOTAL-1]: pixel_valid=0 -> WAIT_RES, tmo_cnt=0.
//    - result_valid seen during START/STREAM is ignored.
//   WAIT_RES: s_ready=0, tmo_cnt++ each cycle.
//    - result_valid=1: frame_done pulse, frames_done++ -> FILL, wr_cnt=0.
//    - Otherwise tmo_cnt==TIMEOUT_CYCLES-1: timeout pulse -> FILL, wr_cnt=0.
//    - result_valid has priority if both occur in the same cycle.
//  Latency:
//   - Accepting the last pixel (edge N) -> start_signal high after edge N+1.
//   - First pixel_valid after edge N+2; last pixel_valid after edge N+1+TOTAL.
//  Edge cases:
//   - s_valid is ignored when s_ready=0; the source must hold data.
//   - s_last on a non-beat cycle is ignored.
//   - Pixel bytes are passed unmodified; no arithmetic on data.
//   - wr_cnt and rd_cnt are AW+1 bits wide so TOTAL is representable.
// STRUCTURE
//  cnn_pkg (shared): IMG_WIDTH, IMG_HEIGHT, TOTAL_PIXELS localparams; typedef enum logic [2:0]
//   {FILL,START,STREAM,WAIT_RES,DROP} feeder_state_t; typedef logic [7:0] pixel_t.
//  Sub-module cnn_frame_ram: single-port sync RAM, TOTAL x 8, 1-cycle read latency.
//   - Written only in FILL, read only in START/STREAM.
//  Top: FSM, counters, output registers.
// TESTING
//  1 Reset then 1024 beats 0..255 repeating, s_last on beat 1023:
//    start_signal 1 cycle; then 1024 contiguous pixel_valid with pixel_in == beat index mod 256.
//  2 Upstream s_valid toggling 50% random: same output stream as 1, contiguous, no gaps.
//  3 s_last on beat 500: frame_err pulse, no start_signal.
//    Next full 1024-beat frame streams correctly.
//  4 1030 beats, s_last on 1030th: frame_err at beat 1024, DROP consumes rest, no start.
//    Next frame OK.
//  5 TIMEOUT_CYCLES=50, result_valid held 0: timeout pulse 50 cycles after last pixel_valid.
//    s_ready=1 next cycle.
//  6 result_valid 10 cycles after last pixel: frame_done pulse, frames_done=1.
//    rst=0 mid-STREAM: pixel_valid=0 next cycle, frames_done=0.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// cnn_pkg
// Shared frame geometry, feeder state encoding and pixel type for CNN_TOP.
// Revision: 1.0
// ============================================================================
package cnn_pkg;

    localparam int IMG_WIDTH    = 32;
    localparam int IMG_HEIGHT   = 32;
    localparam int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT;

    typedef enum logic [2:0] {
        FILL     = 3'd0,
        START    = 3'd1,
        STREAM   = 3'd2,
        WAIT_RES = 3'd3,
        DROP     = 3'd4
    } feeder_state_t;

    typedef logic [7:0] pixel_t;

endpackage
`default_nettype wire

// File: rtl/cnn_frame_ram.sv
`default_nettype none
// ============================================================================
// cnn_frame_ram
// Single-port frame buffer, DEPTH x 8, registered read data (1-cycle latency).
// Revision: 1.0
// ============================================================================
module cnn_frame_ram #(
    parameter int DEPTH = cnn_pkg::TOTAL_PIXELS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);
    import cnn_pkg::*;

    pixel_t mem_q [DEPTH];
    pixel_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Only the read register is reset so the downstream pixel bus starts at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/cnn_frame_feeder.sv
`default_nettype none
// ============================================================================
// cnn_frame_feeder
// Buffers one pixel frame, then replays it to CNN_TOP and waits for its result.
// Revision: 1.0
// ============================================================================
module cnn_frame_feeder #(
    parameter int IMG_WIDTH      = cnn_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT     = cnn_pkg::IMG_HEIGHT,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        start_signal,
    output logic        pixel_valid,
    output logic [7:0]  pixel_in,
    input  logic        result_valid,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic        timeout,
    output logic [15:0] frames_done
);
    import cnn_pkg::*;

    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW    = $clog2(TOTAL);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW:0]   LAST_IDX  = (AW+1)'(TOTAL - 1);
    localparam logic [AW:0]   TOTAL_CNT = (AW+1)'(TOTAL);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    feeder_state_t state_q, state_d;
    logic [AW:0]   wr_cnt_q, wr_cnt_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0]   frames_done_q, frames_done_d;
    pixel_t        pixel_q, pixel_d;
    logic          s_ready_q, s_ready_d;
    logic          start_q, start_d;
    logic          pvalid_q, pvalid_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout_q, timeout_d;

    logic          ram_we, ram_re, beat;
    logic [AW-1:0] ram_addr;
    pixel_t        ram_rdata;

    cnn_frame_ram #(
        .DEPTH (TOTAL),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (s_data),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        frames_done_d = frames_done_q;
        pixel_d       = pixel_q;
        start_d       = 1'b0;
        pvalid_d      = 1'b0;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        timeout_d     = 1'b0;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        ram_addr      = wr_cnt_q[AW-1:0];
        beat          = s_valid & s_ready_q;

        case (state_q)
            FILL: begin
                if (beat) begin
                    ram_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        if (s_last) begin
                            state_d = START;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = DROP;
                        end
                    end else if (s_last) begin
                        frame_err_d = 1'b1;
                        wr_cnt_d    = '0;
                    end
                end
            end
            DROP: begin
                if (beat && s_last) begin
                    state_d  = FILL;
                    wr_cnt_d = '0;
                end
            end
            START: begin
                ram_re   = 1'b1;
                ram_addr = '0;
                rd_cnt_d = (AW+1)'(1);
                start_d  = 1'b1;
                state_d  = STREAM;
            end
            STREAM: begin
                // Read data lags the address by one cycle, so the prefetch runs one pixel ahead.
                pvalid_d = 1'b1;
                pixel_d  = ram_rdata;
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == TOTAL_CNT) begin
                    state_d   = WAIT_RES;
                    tmo_cnt_d = '0;
                end else begin
                    ram_re   = 1'b1;
                    ram_addr = rd_cnt_q[AW-1:0];
                end
            end
            WAIT_RES: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (result_valid) begin
                    frame_done_d  = 1'b1;
                    frames_done_d = frames_done_q + 1'b1;
                    state_d       = FILL;
                    wr_cnt_d      = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = FILL;
                    wr_cnt_d  = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        // Ready rises one cycle after re-entering FILL, never in the cycle that leaves it.
        s_ready_d = ((state_d == FILL) || (state_d == DROP)) &&
                    ((state_q == FILL) || (state_q == DROP));
        busy_d    = (state_d != FILL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= FILL;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            tmo_cnt_q     <= '0;
            frames_done_q <= '0;
            pixel_q       <= '0;
            s_ready_q     <= 1'b0;
            start_q       <= 1'b0;
            pvalid_q      <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            frames_done_q <= frames_done_d;
            pixel_q       <= pixel_d;
            s_ready_q     <= s_ready_d;
            start_q       <= start_d;
            pvalid_q      <= pvalid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            timeout_q     <= timeout_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign start_signal = start_q;
    assign pixel_valid  = pvalid_q;
    assign pixel_in     = pixel_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;
    assign timeout      = timeout_q;
    assign frames_done  = frames_done_q;

endmodule
`default_nettype wire
